// File: rtl/pattern_player.sv
// Steps through one sequence of an external synchronous pattern ROM and drives the LED bank.
// Defining PATTERN_PLAYER_PAUSE_EN adds a pause input that freezes stepping while showing.
module pattern_player #(
    parameter int SEQ_W   = 3,
    parameter int STEP_W  = 4,
    parameter int LED_W   = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                    clk_50,
    input  logic                    reset,
    input  logic [SEQ_W-1:0]        seq_num,
    input  logic                    seq_tick,
`ifdef PATTERN_PLAYER_PAUSE_EN
    input  logic                    pause,
`endif
    input  logic [LED_W:0]          rom_data,
    output logic [SEQ_W+STEP_W-1:0] ROM_addr,
    output logic [LED_W-1:0]        LEDS,
    output logic [STEP_W-1:0]       step,
    output logic                    seq_done
);

    // ROM_LAT is 1..3, so the remaining-wait count always fits in two bits.
    localparam int              CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LAT - 1);

    typedef enum logic [1:0] {FETCH, WAIT, SHOW} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SEQ_W-1:0]          seq_lat_q, seq_lat_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic                      pending_q, pending_d;
    logic                      last_q, last_d;
    logic [LED_W-1:0]          leds_q, leds_d;
    logic                      done_q, done_d;
    logic [SEQ_W+STEP_W-1:0]   addr_q, addr_d;
    logic                      paused;

`ifdef PATTERN_PLAYER_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_lat_d = seq_lat_q;
        step_d    = step_q;
        pending_d = pending_q;
        last_d    = last_q;
        leds_d    = leds_q;
        done_d    = 1'b0;

        // A new selection restarts from step 0 in any state and swallows a coincident tick.
        if (seq_num != seq_lat_q) begin
            seq_lat_d = seq_num;
            step_d    = '0;
            pending_d = 1'b0;
            state_d   = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    cnt_d     = CNT_LOAD;
                    pending_d = paused ? 1'b0 : (pending_q | seq_tick);
                    state_d   = WAIT;
                end
                WAIT: begin
                    pending_d = paused ? 1'b0 : (pending_q | seq_tick);
                    if (cnt_q == '0) begin
                        leds_d  = rom_data[LED_W-1:0];
                        last_d  = rom_data[LED_W];
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (paused) begin
                        pending_d = 1'b0;
                    end else if (seq_tick || pending_q) begin
                        pending_d = 1'b0;
                        state_d   = FETCH;
                        if (last_q || (&step_q)) begin
                            step_d = '0;
                            done_d = 1'b1;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        addr_d = {seq_lat_d, step_d};
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            seq_lat_q <= '0;
            step_q    <= '0;
            pending_q <= 1'b0;
            last_q    <= 1'b0;
            leds_q    <= '0;
            done_q    <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seq_lat_q <= seq_lat_d;
            step_q    <= step_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            leds_q    <= leds_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
        end
    end

    assign ROM_addr = addr_q;
    assign LEDS     = leds_q;
    assign step     = step_q;
    assign seq_done = done_q;

endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Downstream of the sequence selector/debouncer stage.
- Takes the selected sequence number and a one-cycle step tick (slow-clock enable, already in the clk_50 domain).
- Walks that sequence's entries in an external synchronous pattern ROM and drives the LED bank.
- Sole owner of ROM_addr and LEDS.

Parameters:
- SEQ_W, 3: width of seq_num (up to 8 sequences).
- STEP_W, 4: step index width (up to 16 steps per sequence).
- LED_W, 8: LED pattern width.
- ROM_LAT, 1: ROM read latency in clk_50 cycles, legal range 1-3.

Ports:
- clk_50  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- seq_num  input  SEQ_W  selected sequence from upstream; may change on any cycle.
- seq_tick  input  1  one-cycle step-advance pulse.
- rom_data  input  LED_W+1  ROM word: [LED_W] = last-step flag, [LED_W-1:0] = LED pattern.
- ROM_addr  output  SEQ_W+STEP_W  registered ROM address = {seq_lat, step}.
- LEDS  output  LED_W  registered LED pattern.
- step  output  STEP_W  current step index.
- seq_done  output  1  one-cycle pulse when the sequence wraps to step 0.

Behaviour:
- Reset values while reset=0: ROM_addr=0, LEDS=0, step=0, seq_done=0, seq_lat=0, pending=0, last=0, state=FETCH.
- States: FETCH, WAIT, SHOW.
- ROM_addr is always {seq_lat, step}. It updates on the same edge as seq_lat and step.
- FETCH (1 cycle):
  - The address is valid at the ROM.
  - Load wait counter = ROM_LAT-1.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter is 0, capture rom_data: LEDS <= pattern, last <= flag.
  - Go to SHOW.
  - LEDS change exactly ROM_LAT+1 cycles after ROM_addr changes.
- SHOW:
  - Hold LEDS until a seq_tick or pending tick.
  - Advance when last=1 or step=all-ones: step <= 0 and seq_done=1 for one cycle, coincident with step returning to 0.
  - Otherwise step <= step+1.
  - Either case: clear pending, go to FETCH.
- Ticks during FETCH/WAIT:
  - seq_tick sets pending. Ticks are one-deep; extra ticks collapse.
  - On entry to SHOW with pending=1, advance on the first SHOW cycle.
- Sequence change (seq_num != seq_lat), evaluated in every state:
  - seq_lat <= seq_num, step <= 0, pending <= 0, state <= FETCH.
  - seq_done stays 0.
  - LEDS hold their old value until the new entry is captured.
  - Takes priority over a coincident seq_tick; that tick is dropped.
- Step arithmetic is unsigned modulo 2^STEP_W. No overflow beyond the explicit wrap.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). After release, the first cycle is FETCH of {seq_num-at-release latched next cycle, 0}.
  - The change-detect rule covers a nonzero seq_num at release: one FETCH of sequence 0, then restart.

Optional Feature:
- Macro: PATTERN_PLAYER_PAUSE_EN.
- When defined:
  - Adds input pause (1 bit).
  - While pause=1 in SHOW: seq_tick is ignored, not recorded as pending; LEDS and step hold.
  - In FETCH/WAIT, pause does not stall the fetch, but a pending tick is cleared when pause=1.
  - Sequence change still restarts while paused.
- When undefined: no pause port; behaviour is exactly as above.

Test Plan:
- Reset hold, release with seq_num=0, ROM[0]={0,8'hA5}, ROM_LAT=1 -> ROM_addr=0; LEDS=8'hA5 two cycles after the FETCH cycle; step=0; seq_done=0.
- Sequence 2 with ROM[0x22] last flag set; issue 3 ticks spaced 10 cycles -> step 0->1->2->0; seq_done pulses once with the third advance; ROM_addr 0x20,0x21,0x22,0x20.
- Sequence with no last flag in 16 entries; 16 ticks -> step wraps 15->0, seq_done=1 for exactly one cycle.
- seq_tick in FETCH plus a second tick in WAIT -> single advance on the first SHOW cycle; step increments by 1 only.
- seq_num 1->5 in the same cycle as seq_tick while in SHOW at step 3 -> step=0, ROM_addr=0x50, no seq_done, tick dropped; LEDS old until the 0x50 data is captured.
- With PATTERN_PLAYER_PAUSE_EN, pause=1 and 5 ticks in SHOW -> step/LEDS unchanged; pause=0 then 1 tick -> step+1.
